// File: rtl/cache_line_fill_if.sv
// cache_line_fill_if: bundles the refill stream, CPU store-hit port and line
// outputs of cache_line_fill.
//
// Handshake: a refill word moves on every rising edge where mem_valid and
// mem_ready are both high. The source holds mem_data stable while mem_valid
// is high and mem_ready is low. mem_ready depends only on registered state,
// so the source may use it combinationally without creating a loop.
//
// Modports:
//   master - the fill controller / memory side (drives requests and data)
//   slave  - the cache_line_fill block
interface cache_line_fill_if;
  logic         start;
  logic [1:0]   start_sel;
  logic [31:0]  mem_data;
  logic         mem_valid;
  logic         mem_ready;
  logic         cpu_we;
  logic [1:0]   cpu_sel;
  logic [31:0]  cpu_wdata;
  logic [127:0] line_out;
  logic         line_valid;
  logic         busy;
  logic         fill_done;
  logic [1:0]   fsm_state;   // debug view of the fill FSM

  modport master (
    output start, start_sel, mem_data, mem_valid, cpu_we, cpu_sel, cpu_wdata,
    input  mem_ready, line_out, line_valid, busy, fill_done, fsm_state
  );

  modport slave (
    input  start, start_sel, mem_data, mem_valid, cpu_we, cpu_sel, cpu_wdata,
    output mem_ready, line_out, line_valid, busy, fill_done, fsm_state
  );
endinterface

// File: rtl/cache_line_fill.sv
// cache_line_fill: assembles a 4 x 32-bit cache line from a refill stream,
// critical-word-first with wrap, and merges CPU store hits into a completed
// line.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - cache_line_fill_if.slave: start/start_sel request, mem_data/
//           mem_valid/mem_ready refill stream, cpu_we/cpu_sel/cpu_wdata store
//           port, line_out/line_valid/busy/fill_done status, fsm_state debug.
module cache_line_fill (
  input  logic              clk,
  input  logic              rst_n,
  cache_line_fill_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  ptr;
  logic [1:0]  cnt;
  logic        line_valid_q;
  logic [31:0] words [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 2'd0;
      cnt          <= 2'd0;
      line_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) words[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          // A start in the same cycle as a store hit wins; the store is lost
          // because the line is about to be replaced anyway.
          if (bus.start) begin
            state        <= FILL;
            ptr          <= bus.start_sel;
            cnt          <= 2'd0;
            line_valid_q <= 1'b0;
          end else if (bus.cpu_we && line_valid_q) begin
            words[bus.cpu_sel] <= bus.cpu_wdata;
          end
        end
        FILL: begin
          if (bus.mem_valid) begin
            words[ptr] <= bus.mem_data;
            ptr        <= ptr + 2'd1;   // 2-bit wrap gives critical-word-first order
            cnt        <= cnt + 2'd1;
            if (cnt == 2'd3) state <= DONE;
          end
        end
        DONE: begin
          line_valid_q <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decode registered state only.
  assign bus.mem_ready  = (state == FILL);
  assign bus.busy       = (state != IDLE);
  assign bus.fill_done  = (state == DONE);
  assign bus.line_valid = line_valid_q;
  assign bus.line_out   = {words[3], words[2], words[1], words[0]};
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_cache_line_fill.sv
module tb_cache_line_fill;

  logic clk;
  logic rst_n;
  int   cyc;

  cache_line_fill_if bus ();

  cache_line_fill dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [31:0]  model_w [4];
  bit           model_valid;
  logic [31:0]  fill_data  [4];
  int           fill_stall [4];

  int total;
  int bad;

  logic [127:0] exp_q [$];
  int           exp_cyc_q [$];

  function automatic logic [127:0] pack_line(input logic [31:0] w [4]);
    return {w[3], w[2], w[1], w[0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit chk_lv;
  initial chk_lv = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk_lv = 0;
    end else begin
      if (chk_lv) begin
        check("line_valid_after_done", {126'd0, bus.line_valid, bus.fill_done}, 128'd2);
        chk_lv = 0;
      end
      if (bus.fill_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fill_done", 128'd1, 128'd0);
        end else begin
          check("fill_line", bus.line_out, exp_q.pop_front());
          check("fill_done_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
        end
        chk_lv = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cpu_rand();
    bus.cpu_we    = 1'b1;
    bus.cpu_sel   = 2'($urandom_range(0, 3));
    bus.cpu_wdata = $urandom;
  endtask

  task automatic cpu_write(input logic [1:0] sel, input logic [31:0] data);
    bus.cpu_we    = 1'b1;
    bus.cpu_sel   = sel;
    bus.cpu_wdata = data;
    tick();
    bus.cpu_we = 1'b0;
    if (model_valid) model_w[sel] = data;
    check("cpu_write_line", bus.line_out, pack_line(model_w));
    check("cpu_write_lv", {127'd0, bus.line_valid}, {127'd0, model_valid});
  endtask

  task automatic do_fill(input logic [1:0] sel, input bit cpu_with_start,
                         input bit cpu_in_fill, input bit cpu_in_done);
    logic [31:0] w [4];
    logic [1:0]  idx;
    int          s;
    int          e;
    w = model_w;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      idx = sel + 2'(k);
      w[idx] = fill_data[k];
      s += fill_stall[k];
    end
    exp_q.push_back(pack_line(w));

    bus.start     = 1'b1;
    bus.start_sel = sel;
    if (cpu_with_start) drive_cpu_rand();
    tick();
    bus.start  = 1'b0;
    bus.cpu_we = 1'b0;
    e = cyc;
    exp_cyc_q.push_back(e + 4 + s);
    model_valid = 0;
    check("start_line_hold", bus.line_out, pack_line(model_w));
    check("start_status", {125'd0, bus.line_valid, bus.mem_ready, bus.busy}, 128'd3);

    idx = sel;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < fill_stall[k]; j++) begin
        bus.mem_valid = 1'b0;
        bus.mem_data  = $urandom;
        if (cpu_in_fill) drive_cpu_rand();
        tick();
        bus.cpu_we = 1'b0;
        check("stall_hold", bus.line_out, pack_line(model_w));
      end
      bus.mem_valid = 1'b1;
      bus.mem_data  = fill_data[k];
      if (cpu_in_fill) drive_cpu_rand();
      tick();
      bus.mem_valid = 1'b0;
      bus.cpu_we    = 1'b0;
      model_w[idx]  = fill_data[k];
      idx           = idx + 2'd1;
      check("fill_partial", bus.line_out, pack_line(model_w));
    end

    // One-cycle completion state
    check("done_status", {126'd0, bus.busy, bus.mem_ready}, 128'd2);
    if (cpu_in_done) drive_cpu_rand();
    tick();
    bus.cpu_we = 1'b0;
    model_valid = 1;
    check("after_fill_line", bus.line_out, pack_line(model_w));
    check("after_fill_status", {125'd0, bus.line_valid, bus.mem_ready, bus.busy}, 128'd4);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {bus.line_out, 4'd0} >> 4 | {124'd0, bus.line_valid, bus.mem_ready, bus.busy, bus.fill_done}
          , 128'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    model_valid = 0;
    for (int i = 0; i < 4; i++) model_w[i] = 32'd0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.start_sel = 2'd0;
    bus.mem_data  = 32'd0;
    bus.mem_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_sel   = 2'd0;
    bus.cpu_wdata = 32'd0;

    repeat (3) tick();
    check("reset_line", bus.line_out, 128'd0);
    check("reset_status", {124'd0, bus.line_valid, bus.mem_ready, bus.busy, bus.fill_done}, 128'd0);
    rst_n = 1'b1;
    tick();
    check("post_reset_line", bus.line_out, 128'd0);
    check("post_reset_status", {124'd0, bus.line_valid, bus.mem_ready, bus.busy, bus.fill_done}, 128'd0);

    // Store hit with no valid line is ignored
    cpu_write(2'd1, 32'h1234_5678);

    // Aligned fill, back-to-back
    fill_data[0] = 32'd100; fill_data[1] = 32'd200; fill_data[2] = 32'd300; fill_data[3] = 32'd400;
    for (int k = 0; k < 4; k++) fill_stall[k] = 0;
    do_fill(2'd0, 0, 0, 0);

    cpu_write(2'd1, 32'h0000_DEAD);

    // Wrapped fill with store attempts during FILL and DONE
    fill_data[0] = 32'hA; fill_data[1] = 32'hB; fill_data[2] = 32'hC; fill_data[3] = 32'hD;
    do_fill(2'd2, 0, 1, 1);

    // Three-cycle stall between words 1 and 2, store together with start
    for (int k = 0; k < 4; k++) fill_data[k] = $urandom;
    fill_stall[2] = 3;
    do_fill(2'd1, 1, 0, 0);
    fill_stall[2] = 0;

    // Reset after two accepted words
    bus.start = 1'b1; bus.start_sel = 2'd3;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.mem_valid = 1'b1;
      bus.mem_data  = $urandom;
      tick();
    end
    bus.mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midfill_reset_line", bus.line_out, 128'd0);
    check("midfill_reset_status", {124'd0, bus.line_valid, bus.mem_ready, bus.busy, bus.fill_done}, 128'd0);
    for (int i = 0; i < 4; i++) model_w[i] = 32'd0;
    model_valid = 0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 4; k++) fill_data[k] = $urandom;
    do_fill(2'd3, 0, 0, 0);

    // Randomized fills and store hits
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < 4; k++) begin
        fill_data[k]  = $urandom;
        fill_stall[k] = $urandom_range(0, 2);
      end
      do_fill(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int m = 0; m < int'($urandom_range(0, 2)); m++)
        cpu_write(2'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    check("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
